// File: rtl/pq_shift_param.sv
// Sorted shift-register priority queue with parametrised key/value width and depth,
// min/max-first ordering, same-cycle replace and optional evict-on-overflow.
module pq_shift_param #(
  parameter int unsigned KW        = 8,
  parameter int unsigned VW        = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          MAX_FIRST = 1'b1,
  parameter bit          EVICT     = 1'b0,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] kvi_key,
  input  logic [VW-1:0] kvi_val,
  input  logic          enq,
  input  logic          deq,
  output logic [KW-1:0] kvo_key,
  output logic [VW-1:0] kvo_val,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          drop,
  output logic [KW-1:0] drop_key,
  output logic [VW-1:0] drop_val
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [KW-1:0]    key_q  [DEPTH];
  logic [VW-1:0]    val_q  [DEPTH];
  logic [KW-1:0]    key_d  [DEPTH];
  logic [VW-1:0]    val_d  [DEPTH];
  logic [KW-1:0]    key_dn [DEPTH];
  logic [VW-1:0]    val_dn [DEPTH];
  logic [KW-1:0]    key_up [DEPTH];
  logic [VW-1:0]    val_up [DEPTH];
  logic [DEPTH-1:0] ge, ge_up, ge_dn;

  logic          do_rep, do_deq, do_ins, do_rej, enq_only;
  logic [CW-1:0] count_d;
  logic          drop_d;
  logic [KW-1:0] drop_key_d;
  logic [VW-1:0] drop_val_d;

  // ge[i]: valid entry i has priority >= the incoming key (ties count, giving FIFO order).
  // Since storage is sorted, ge is a contiguous prefix and its length is the insert position.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ge     = '0;
    ge_up  = '0;
    ge_dn  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      key_dn[i] = '0;
      val_dn[i] = '0;
      key_up[i] = '0;
      val_up[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count)
        ge[i] = MAX_FIRST ? (key_q[i] >= kvi_key) : (key_q[i] <= kvi_key);
    end
    ge_up[0] = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      ge_up[i]  = ge[i-1];
      key_up[i] = key_q[i-1];
      val_up[i] = val_q[i-1];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      ge_dn[i]  = ge[i+1];
      key_dn[i] = key_q[i+1];
      val_dn[i] = val_q[i+1];
    end
  end

  always_comb begin
    do_rep   = enq && deq && !empty;
    do_deq   = deq && !enq && !empty;
    enq_only = enq && !do_rep;
    do_ins   = enq_only && (!full || (EVICT && !ge[DEPTH-1]));
    do_rej   = enq_only && !do_ins;

    key_d      = key_q;
    val_d      = val_q;
    count_d    = count;
    drop_d     = 1'b0;
    drop_key_d = '0;
    drop_val_d = '0;

    if (do_deq) begin
      key_d   = key_dn;
      val_d   = val_dn;
      count_d = count - 1'b1;
    end else if (do_rep) begin
      // Head leaves; new entry lands at max(p-1,0) of the remaining list.
      for (int i = 0; i < DEPTH; i++) begin
        if (ge_dn[i]) begin
          key_d[i] = key_dn[i];
          val_d[i] = val_dn[i];
        end else if (i == 0 || ge[i]) begin
          key_d[i] = kvi_key;
          val_d[i] = kvi_val;
        end
      end
    end else if (do_ins) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!ge[i]) begin
          key_d[i] = ge_up[i] ? kvi_key : key_up[i];
          val_d[i] = ge_up[i] ? kvi_val : val_up[i];
        end
      end
      if (full) begin
        drop_d     = 1'b1;
        drop_key_d = key_q[DEPTH-1];
        drop_val_d = val_q[DEPTH-1];
      end else begin
        count_d = count + 1'b1;
      end
    end else if (do_rej) begin
      drop_d     = 1'b1;
      drop_key_d = kvi_key;
      drop_val_d = kvi_val;
    end
  end

  // NOTE: entry storage is not reset; validity comes from count, so stale data is never visible.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    key_q <= key_d;
    val_q <= val_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      drop     <= 1'b0;
      drop_key <= '0;
      drop_val <= '0;
    end else begin
      count    <= count_d;
      full     <= (count_d == FULL_CNT);
      empty    <= (count_d == '0);
      drop     <= drop_d;
      drop_key <= drop_key_d;
      drop_val <= drop_val_d;
    end
  end

  assign kvo_key = empty ? '0 : key_q[0];
  assign kvo_val = empty ? '0 : val_q[0];
  assign busy    = 1'b0;

endmodule

// File: tb/tb_pq_shift_param.sv
// Directed bench for pq_shift_param: three DEPTH=4 instances (max/reject, min, max/evict)
// share stimulus; each test task resets first and checks the instance it targets.
module tb_pq_shift_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] kvi_key = '0;
  logic [7:0] kvi_val = '0;
  logic       enq = 1'b0;
  logic       deq = 1'b0;

  logic [7:0] mx_key, mx_val, mx_dkey, mx_dval;
  logic       mx_full, mx_empty, mx_busy, mx_drop;
  logic [2:0] mx_count;
  logic [7:0] mn_key, mn_val, mn_dkey, mn_dval;
  logic       mn_full, mn_empty, mn_busy, mn_drop;
  logic [2:0] mn_count;
  logic [7:0] ev_key, ev_val, ev_dkey, ev_dval;
  logic       ev_full, ev_empty, ev_busy, ev_drop;
  logic [2:0] ev_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pq_shift_param #(.KW(8), .VW(8), .DEPTH(4), .MAX_FIRST(1'b1), .EVICT(1'b0)) u_max (
    .clk(clk), .rst(rst), .kvi_key(kvi_key), .kvi_val(kvi_val), .enq(enq), .deq(deq),
    .kvo_key(mx_key), .kvo_val(mx_val), .full(mx_full), .empty(mx_empty), .busy(mx_busy),
    .count(mx_count), .drop(mx_drop), .drop_key(mx_dkey), .drop_val(mx_dval));

  pq_shift_param #(.KW(8), .VW(8), .DEPTH(4), .MAX_FIRST(1'b0), .EVICT(1'b0)) u_min (
    .clk(clk), .rst(rst), .kvi_key(kvi_key), .kvi_val(kvi_val), .enq(enq), .deq(deq),
    .kvo_key(mn_key), .kvo_val(mn_val), .full(mn_full), .empty(mn_empty), .busy(mn_busy),
    .count(mn_count), .drop(mn_drop), .drop_key(mn_dkey), .drop_val(mn_dval));

  pq_shift_param #(.KW(8), .VW(8), .DEPTH(4), .MAX_FIRST(1'b1), .EVICT(1'b1)) u_ev (
    .clk(clk), .rst(rst), .kvi_key(kvi_key), .kvi_val(kvi_val), .enq(enq), .deq(deq),
    .kvo_key(ev_key), .kvo_val(ev_val), .full(ev_full), .empty(ev_empty), .busy(ev_busy),
    .count(ev_count), .drop(ev_drop), .drop_key(ev_dkey), .drop_val(ev_dval));

  // One request cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic op(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
    @(negedge clk);
    enq = e; deq = d; kvi_key = k; kvi_val = v;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; enq = 1'b1; kvi_key = 8'd7; kvi_val = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0; enq = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (mx_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", mx_empty); end
    checks++; if (mx_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", mx_full); end
    checks++; if (mx_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", mx_count); end
    checks++; if (mx_key !== 8'd0 || mx_val !== 8'd0) begin failures++; $display("FAIL reset_kvo got=%0d/%0d exp=0/0", mx_key, mx_val); end
    checks++; if (mx_drop !== 1'b0 || mx_busy !== 1'b0) begin failures++; $display("FAIL reset_drop_busy got=%b%b exp=00", mx_drop, mx_busy); end
  endtask

  task automatic test_ordering();
    logic [7:0] exp_k [4];
    logic [7:0] exp_v [4];
    exp_k = '{8'd9, 8'd5, 8'd5, 8'd1};
    exp_v = '{8'h01, 8'h0A, 8'h0B, 8'h02};
    do_reset();
    op(1, 0, 8'd5, 8'h0A);
    op(1, 0, 8'd9, 8'h01);
    checks++; if (mx_key !== 8'd9) begin failures++; $display("FAIL order_head_after_9 got=%0d exp=9", mx_key); end
    op(1, 0, 8'd5, 8'h0B);
    op(1, 0, 8'd1, 8'h02);
    checks++; if (mx_full !== 1'b1 || mx_count !== 3'd4) begin failures++; $display("FAIL order_full got=%b/%0d exp=1/4", mx_full, mx_count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mx_key !== exp_k[i] || mx_val !== exp_v[i]) begin
        failures++; $display("FAIL order_deq%0d got=%0d/%h exp=%0d/%h", i, mx_key, mx_val, exp_k[i], exp_v[i]);
      end
      op(0, 1, 8'd0, 8'd0);
    end
    checks++; if (mx_empty !== 1'b1 || mx_count !== 3'd0) begin failures++; $display("FAIL order_empty got=%b/%0d exp=1/0", mx_empty, mx_count); end
    op(0, 1, 8'd0, 8'd0);
    checks++; if (mx_empty !== 1'b1 || mx_count !== 3'd0 || mx_drop !== 1'b0 || mx_key !== 8'd0) begin
      failures++; $display("FAIL order_deq_empty got=%b/%0d/%b/%0d exp=1/0/0/0", mx_empty, mx_count, mx_drop, mx_key);
    end
  endtask

  task automatic test_min_mode();
    logic [7:0] exp_k [3];
    exp_k = '{8'd3, 8'd7, 8'd8};
    do_reset();
    op(1, 0, 8'd7, 8'h70);
    op(1, 0, 8'd3, 8'h30);
    checks++; if (mn_key !== 8'd3 || mn_val !== 8'h30) begin failures++; $display("FAIL min_head got=%0d/%h exp=3/30", mn_key, mn_val); end
    op(1, 0, 8'd8, 8'h80);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mn_key !== exp_k[i]) begin failures++; $display("FAIL min_deq%0d got=%0d exp=%0d", i, mn_key, exp_k[i]); end
      op(0, 1, 8'd0, 8'd0);
    end
    checks++; if (mn_empty !== 1'b1) begin failures++; $display("FAIL min_empty got=%b exp=1", mn_empty); end
  endtask

  task automatic test_full_reject();
    do_reset();
    op(1, 0, 8'd10, 8'h1A);
    op(1, 0, 8'd20, 8'h2A);
    op(1, 0, 8'd30, 8'h3A);
    op(1, 0, 8'd40, 8'h4A);
    checks++; if (mx_full !== 1'b1 || mx_empty !== 1'b0) begin failures++; $display("FAIL rej_full got=%b/%b exp=1/0", mx_full, mx_empty); end
    op(1, 0, 8'd50, 8'h5A);
    checks++; if (mx_drop !== 1'b1 || mx_dkey !== 8'd50 || mx_dval !== 8'h5A) begin
      failures++; $display("FAIL rej_drop got=%b/%0d/%h exp=1/50/5a", mx_drop, mx_dkey, mx_dval);
    end
    checks++; if (mx_count !== 3'd4 || mx_key !== 8'd40) begin failures++; $display("FAIL rej_state got=%0d/%0d exp=4/40", mx_count, mx_key); end
    op(0, 0, 8'd0, 8'd0);
    checks++; if (mx_drop !== 1'b0) begin failures++; $display("FAIL rej_drop_pulse got=%b exp=0", mx_drop); end
  endtask

  task automatic test_evict();
    logic [7:0] exp_k [4];
    exp_k = '{8'd40, 8'd30, 8'd25, 8'd20};
    do_reset();
    op(1, 0, 8'd10, 8'h1A);
    op(1, 0, 8'd20, 8'h2A);
    op(1, 0, 8'd30, 8'h3A);
    op(1, 0, 8'd40, 8'h4A);
    op(1, 0, 8'd25, 8'h25);
    checks++; if (ev_drop !== 1'b1 || ev_dkey !== 8'd10 || ev_dval !== 8'h1A) begin
      failures++; $display("FAIL ev_drop10 got=%b/%0d/%h exp=1/10/1a", ev_drop, ev_dkey, ev_dval);
    end
    checks++; if (ev_count !== 3'd4) begin failures++; $display("FAIL ev_count got=%0d exp=4", ev_count); end
    op(1, 0, 8'd5, 8'h05);
    checks++; if (ev_drop !== 1'b1 || ev_dkey !== 8'd5 || ev_dval !== 8'h05) begin
      failures++; $display("FAIL ev_drop5 got=%b/%0d/%h exp=1/5/05", ev_drop, ev_dkey, ev_dval);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ev_key !== exp_k[i]) begin failures++; $display("FAIL ev_deq%0d got=%0d exp=%0d", i, ev_key, exp_k[i]); end
      op(0, 1, 8'd0, 8'd0);
    end
  endtask

  task automatic test_replace();
    logic [7:0] exp_k [4];
    exp_k = '{8'd30, 8'd20, 8'd10, 8'd1};
    do_reset();
    op(1, 0, 8'd40, 8'h40);
    op(1, 0, 8'd30, 8'h30);
    op(1, 0, 8'd20, 8'h20);
    op(1, 0, 8'd10, 8'h10);
    op(1, 1, 8'd35, 8'h35);
    checks++; if (mx_key !== 8'd35 || mx_count !== 3'd4 || mx_drop !== 1'b0) begin
      failures++; $display("FAIL rep_35 got=%0d/%0d/%b exp=35/4/0", mx_key, mx_count, mx_drop);
    end
    op(1, 1, 8'd1, 8'h01);
    checks++; if (mx_key !== 8'd30 || mx_count !== 3'd4 || mx_full !== 1'b1) begin
      failures++; $display("FAIL rep_1 got=%0d/%0d/%b exp=30/4/1", mx_key, mx_count, mx_full);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mx_key !== exp_k[i]) begin failures++; $display("FAIL rep_deq%0d got=%0d exp=%0d", i, mx_key, exp_k[i]); end
      op(0, 1, 8'd0, 8'd0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    op(1, 1, 8'd6, 8'h66);
    checks++; if (mx_count !== 3'd1 || mx_key !== 8'd6 || mx_val !== 8'h66) begin
      failures++; $display("FAIL b2b_rep_empty got=%0d/%0d/%h exp=1/6/66", mx_count, mx_key, mx_val);
    end
    op(1, 0, 8'd9, 8'h99);
    op(1, 1, 8'd2, 8'h22);
    checks++; if (mx_count !== 3'd2 || mx_key !== 8'd6) begin
      failures++; $display("FAIL b2b_rep got=%0d/%0d exp=2/6", mx_count, mx_key);
    end
    @(negedge clk);
    rst = 1'b1; enq = 1'b1; kvi_key = 8'd50;
    @(posedge clk);
    #1;
    rst = 1'b0; enq = 1'b0;
    checks++; if (mx_count !== 3'd0 || mx_empty !== 1'b1 || mx_drop !== 1'b0 || mx_key !== 8'd0) begin
      failures++; $display("FAIL b2b_midrst got=%0d/%b/%b/%0d exp=0/1/0/0", mx_count, mx_empty, mx_drop, mx_key);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_min_mode();
    test_full_reject();
    test_evict();
    test_replace();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pq_shift_param.md
# pq_shift_param

Parametrised sorted shift-register priority queue implementing the `dev` side of the team's priority-queue handshake (`enq`/`deq`/`full`/`busy`/`empty`/`kvo`). It adds three things to the fixed-`kv_t` queue generation:

- key width, value width and depth set by parameters;
- selectable min- or max-first ordering;
- same-cycle replace (enqueue plus dequeue), and an optional evict-lowest policy on overflow.

It sits between a scheduler client and the downstream consumer. All operations complete in one cycle.

## Interface

- `KW`, 8: key width in bits (≥1).
- `VW`, 8: value width in bits (≥1).
- `DEPTH`, 16: number of entries (≥2).
- `MAX_FIRST`, 1: 1 means the largest key is the head; 0 means the smallest key is the head.
- `EVICT`, 0: 0 means an enq on a full queue is rejected; 1 means it evicts the lowest-priority entry.
- `clk` input, 1: single clock, all logic on the rising edge.
- `rst` input, 1: reset is synchronous and active-high.
- `kvi_key` input, KW: key to enqueue.
- `kvi_val` input, VW: value to enqueue.
- `enq` input, 1: enqueue request, sampled on every rising edge.
- `deq` input, 1: dequeue-head request, sampled on every rising edge.
- `kvo_key` output, KW: head key.
- `kvo_val` output, VW: head value.
- `full` output, 1: count == DEPTH.
- `empty` output, 1: count == 0.
- `busy` output, 1: constant 0; kept for handshake compatibility because every operation completes in one cycle.
- `count` output, $clog2(DEPTH+1): number of valid entries.
- `drop` output, 1: one-cycle pulse when an entry is discarded by a reject or an eviction.
- `drop_key` output, KW: key of the discarded entry, valid while `drop` is high.
- `drop_val` output, VW: value of the discarded entry, valid while `drop` is high.

## Operation

**Storage**
- Entries E[0..DEPTH-1] each hold a key, a value and a valid bit.
- Valid entries are contiguous from index 0 and sorted by priority; E[0] is the head.
- Ordering is strict on key. Among equal keys order is FIFO: a new entry is placed after every existing equal-key entry.

**Insert position**
- Every entry compares `kvi_key` against its own key in parallel.
- p = number of valid entries with priority ≥ the new key (ties count as ≥).

**Per-edge actions, with c = count**
- rst: all valid bits, `count`, `drop`, `kvo_*` and `drop_*` go to 0. `empty` goes to 1 and `full` to 0. rst overrides enq and deq.
- Neither enq nor deq: hold.
- deq only, c>0: shift E[1..] down one place; count decrements.
- deq only, c==0: ignored; no state change and no `drop`.
- enq only, c<DEPTH: entries from p upward shift up one place; new entry written to E[p]; count increments.
- enq only, c==DEPTH, EVICT=0: queue unchanged. `drop` fires with the incoming key/value.
- enq only, c==DEPTH, EVICT=1, and the new key has strictly higher priority than E[DEPTH-1]:
  - insert at p; old E[DEPTH-1] falls off the end;
  - `drop` fires with the old E[DEPTH-1];
  - count stays DEPTH.
- enq only, c==DEPTH, EVICT=1, otherwise: `drop` fires with the incoming entry; queue unchanged.
- enq+deq, c>0 (replace):
  - the head is removed and the new entry is inserted at position max(p-1,0) of the remaining list;
  - count unchanged; allowed even when full; never produces `drop`.
- enq+deq, c==0: treated as enq only.

**Outputs**
- `kvo_key`/`kvo_val` are driven from registered E[0]. Both read 0 when empty.
- `full`, `empty` and `count` are registered and consistent with the stored state.

## Timing

- Operation latency is one cycle: request sampled at edge N; `kvo`, `count`, `full`, `empty` and `drop` reflect it after edge N.
- The client samples `kvo` before the edge on which it asserts `deq`. The dequeued item is the `kvo` visible during that cycle.
- Back-to-back operations are accepted on every cycle with no bubbles. `busy` is never asserted.
- `drop` is high for exactly the one cycle after the offending edge; otherwise it is 0.
- Rst asserted mid-stream clears the queue on that edge. Requests in the same cycle are discarded with no `drop`.
- Combinational path: compare of `kvi_key` against all entries, then priority encode, then write. No comparator chain across entries.

## Test plan

- **Reset:** assert rst with enq=1 for 2 cycles, then release → empty=1, full=0, count=0, kvo=0, drop=0.
- **Ordering and ties** (DEPTH=4, MAX_FIRST=1): enq keys 5, 9, 5(val 0xB), 1 with the first 5 carrying val 0xA → deq order 9, 5/0xA, 5/0xB, 1; empty=1 after the 4th deq; a further deq changes nothing.
- **Min mode** (MAX_FIRST=0): enq 7, 3, 8 → kvo_key=3 one cycle after the enq of 3; then deq yields 3, 7, 8.
- **Full reject** (EVICT=0, DEPTH=4): fill with 10, 20, 30, 40 → full=1; enq 50 → drop=1 with drop_key=50 for one cycle; count=4; kvo_key=40.
- **Evict** (EVICT=1, DEPTH=4, MAX_FIRST=1): fill 10, 20, 30, 40; enq 25 → drop_key=10 and contents 40, 30, 25, 20. Enq 5 → drop_key=5 and contents unchanged.
- **Replace**: with the queue full of 40, 30, 20, 10, assert enq=1 key 35 together with deq=1 → kvo_key becomes 35, count=4, drop=0. Replace with key 1 → contents 30, 20, 10, 1.
